// File: rtl/psum_pkg.sv
// ============================================================================
// psum_pkg: shared types and constants for the partial-sum issue controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package psum_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int PSUM_IN_W       = 4;
  localparam int PSUM_OUT_W      = 6;
  localparam int DEF_CHANNEL_NUM = 128;
  localparam int DEF_MACRO_NUM   = 4;

endpackage

`default_nettype wire

// File: rtl/psum_pix_counter.sv
// ============================================================================
// psum_pix_counter: pixel/row position counter with wrap and last-pixel flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module psum_pix_counter
  import psum_pkg::*;
#(
  parameter int PIX_PER_ROW = 32,
  parameter int ROW_NUM     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           inc,
  output logic [$clog2(PIX_PER_ROW)-1:0] pix_cnt,
  output logic [$clog2(ROW_NUM)-1:0]     row_cnt,
  output logic                           last
);

  localparam int PW = $clog2(PIX_PER_ROW);
  localparam int RW = $clog2(ROW_NUM);

  logic pix_last;
  logic row_last;

  assign pix_last = (pix_cnt == PW'(PIX_PER_ROW - 1));
  assign row_last = (row_cnt == RW'(ROW_NUM - 1));
  assign last     = pix_last && row_last;

  // The final increment of a frame wraps both counters back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pix_cnt <= '0;
      row_cnt <= '0;
    end else if (inc) begin
      if (pix_last) begin
        pix_cnt <= '0;
        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/psum_sched.sv
// ============================================================================
// psum_sched: collects skewed per-macro results and issues one aligned beat.
// Optional collection timeout built when PSUM_SCHED_TIMEOUT_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module psum_sched
  import psum_pkg::*;
#(
  parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
  parameter int MACRO_NUM   = DEF_MACRO_NUM,
  parameter int PIX_PER_ROW = 32,
  parameter int ROW_NUM     = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [MACRO_NUM-1:0]                      macro_valid,
  input  logic [MACRO_NUM*CHANNEL_NUM*PSUM_IN_W-1:0] macro_data,
  output logic [MACRO_NUM-1:0]                      macro_ack,
  output logic                                      psum_valid,
  output logic [MACRO_NUM*CHANNEL_NUM*PSUM_IN_W-1:0] psum_data,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic                                      err_timeout,
  output logic [$clog2(PIX_PER_ROW)-1:0]            pix_cnt,
  output logic [$clog2(ROW_NUM)-1:0]                row_cnt
);

  localparam int SW = CHANNEL_NUM * PSUM_IN_W;

  state_t                     state, state_nx;
  logic [MACRO_NUM-1:0]       mask;
  logic [MACRO_NUM-1:0]       capture;
  logic [MACRO_NUM-1:0]       take;
  logic [MACRO_NUM*SW-1:0]    hold;
  logic                       full_nx;
  logic                       accept_start;
  logic                       last_pix;
  logic                       timeout_hit;

  assign accept_start = (state == IDLE) && start;
  assign capture      = (state == COLLECT) ? (macro_valid & ~mask) : '0;
  assign full_nx      = &(mask | capture);
  // An expiring pixel drops everything, including arrivals in that cycle.
  assign take         = timeout_hit ? '0 : capture;

  assign psum_valid = (state == ISSUE);
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);
  assign psum_data  = hold;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = COLLECT;
      COLLECT: if (full_nx) state_nx = ISSUE;
      ISSUE:   state_nx = last_pix ? DONE : COLLECT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask      <= '0;
      macro_ack <= '0;
      hold      <= '0;
    end else begin
      state     <= state_nx;
      macro_ack <= take;
      if (accept_start || (state == ISSUE) || timeout_hit)
        mask <= '0;
      else
        mask <= mask | take;
      for (int m = 0; m < MACRO_NUM; m++)
        if (take[m]) hold[m*SW +: SW] <= macro_data[m*SW +: SW];
    end
  end

  psum_pix_counter #(
    .PIX_PER_ROW (PIX_PER_ROW),
    .ROW_NUM     (ROW_NUM)
  ) u_pix_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept_start),
    .inc     (state == ISSUE),
    .pix_cnt (pix_cnt),
    .row_cnt (row_cnt),
    .last    (last_pix)
  );

`ifdef PSUM_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          partial;
  logic          err_q;

  // Counts cycles spent waiting with some, but not all, macros in hand.
  assign partial     = (state == COLLECT) && (mask != '0) && !full_nx;
  assign timeout_hit = partial && (tmo_cnt == TW'(TIMEOUT - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (accept_start) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (timeout_hit) begin
      tmo_cnt <= '0;
      err_q   <= 1'b1;
    end else if (partial) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_psum_sched.sv
// ============================================================================
// tb_psum_sched: directed vector table plus timeout/reset corner sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_psum_sched;

  localparam int CH  = 4;
  localparam int M   = 4;
  localparam int PIX = 2;
  localparam int ROW = 2;
  localparam int TMO = 12;
  localparam int DW  = M * CH * 4;
  localparam int NV  = 29;

  localparam logic [63:0] D7 = {16{4'h7}};
  localparam logic [63:0] P1 = {16'h8091, 16'h5E6F, 16'h3C4D, 16'h1A2B};
  localparam logic [63:0] X  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] Y  = 64'h0F0F_F0F0_8888_1111;
  localparam logic [63:0] Z  = 64'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [M-1:0]  macro_valid = '0;
  logic [DW-1:0] macro_data = '0;
  logic [M-1:0]  macro_ack;
  logic          psum_valid;
  logic [DW-1:0] psum_data;
  logic          busy;
  logic          frame_done;
  logic          err_timeout;
  logic          pix_cnt;
  logic          row_cnt;

  always #5 clk = ~clk;

  psum_sched #(
    .CHANNEL_NUM (CH),
    .MACRO_NUM   (M),
    .PIX_PER_ROW (PIX),
    .ROW_NUM     (ROW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .macro_valid (macro_valid),
    .macro_data  (macro_data),
    .macro_ack   (macro_ack),
    .psum_valid  (psum_valid),
    .psum_data   (psum_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .pix_cnt     (pix_cnt),
    .row_cnt     (row_cnt)
  );

  typedef struct {
    logic        r;
    logic        s;
    logic [3:0]  v;
    logic [63:0] d;
    logic [3:0]  ack;
    logic        pv;
    logic        cpd;
    logic [63:0] pd;
    logic        bsy;
    logic        dn;
    logic        pix;
    logic        row;
  } vec_t;

  vec_t tbl [NV];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic [3:0] v, input logic [63:0] d);
    rst         = r;
    start       = s;
    macro_valid = v;
    macro_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          r     s     v      d   ack    pv    cpd   pd  bsy   dn    pix   row
    tbl[0]  = '{1'b1, 1'b0, 4'h0, Z,  4'h0, 1'b0, 1'b1, Z,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'h0, Z,  4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'hF, D7, 4'hF, 1'b1, 1'b1, D7, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'hF, D7, 4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h1, P1, 4'h1, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'h1, P1, 4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, P1, 4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'h2, P1, 4'h2, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'h2, P1, 4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h4, P1, 4'h4, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'h4, P1, 4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'h4, P1, 4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'h4, P1, 4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'hC, P1, 4'h8, 1'b1, 1'b1, P1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'h8, P1, 4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'hF, X,  4'hF, 1'b1, 1'b1, X,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 4'hF, X,  4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 4'hF, Y,  4'hF, 1'b1, 1'b1, Y,  1'b1, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 4'hF, Y,  4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 4'h0, Z,  4'h0, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 4'h0, Z,  4'h0, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 4'h0, Z,  4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 4'h7, Y,  4'h7, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 4'h7, Y,  4'h0, 1'b0, 1'b1, Z,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 4'h8, Y,  4'h0, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 4'h8, Y,  4'h0, 1'b0, 1'b0, Z,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b1, 4'h8, Y,  4'h0, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[27] = '{1'b0, 1'b0, 4'h8, Y,  4'h8, 1'b0, 1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[28] = '{1'b1, 1'b0, 4'h0, Z,  4'h0, 1'b0, 1'b1, Z,  1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].d);
      chk($sformatf("v%0d ack", i),  64'(macro_ack),   64'(tbl[i].ack));
      chk($sformatf("v%0d pv", i),   64'(psum_valid),  64'(tbl[i].pv));
      chk($sformatf("v%0d busy", i), 64'(busy),        64'(tbl[i].bsy));
      chk($sformatf("v%0d done", i), 64'(frame_done),  64'(tbl[i].dn));
      chk($sformatf("v%0d pix", i),  64'(pix_cnt),     64'(tbl[i].pix));
      chk($sformatf("v%0d row", i),  64'(row_cnt),     64'(tbl[i].row));
      chk($sformatf("v%0d err", i),  64'(err_timeout), 64'(0));
      if (tbl[i].cpd)
        chk($sformatf("v%0d data", i), psum_data, tbl[i].pd);
    end

    // Only macro 0 arrives; the pixel should expire TMO cycles after capture.
    tick(1'b0, 1'b1, 4'h0, Z);
    tick(1'b0, 1'b0, 4'h1, Y);
    chk("tmo ack0", 64'(macro_ack), 64'(4'h1));
    for (int k = 1; k < TMO; k++) begin
      tick(1'b0, 1'b0, 4'h0, Y);
      chk($sformatf("tmo wait%0d err", k), 64'(err_timeout), 64'(0));
    end
    tick(1'b0, 1'b0, 4'h0, Y);
`ifdef PSUM_SCHED_TIMEOUT_EN
    chk("tmo err set", 64'(err_timeout), 64'(1));
`else
    chk("tmo err tied", 64'(err_timeout), 64'(0));
`endif
    chk("tmo busy", 64'(busy), 64'(1));
    chk("tmo pix", 64'(pix_cnt), 64'(0));

    tick(1'b0, 1'b0, 4'hF, X);
    chk("post pv", 64'(psum_valid), 64'(1));
`ifdef PSUM_SCHED_TIMEOUT_EN
    chk("post ack", 64'(macro_ack), 64'(4'hF));
    chk("post data", psum_data, X);
`else
    chk("post ack", 64'(macro_ack), 64'(4'hE));
    chk("post data", psum_data, {X[63:16], Y[15:0]});
`endif
    tick(1'b0, 1'b0, 4'hF, X);
    chk("post pix", 64'(pix_cnt), 64'(1));
    chk("post pv off", 64'(psum_valid), 64'(0));
`ifdef PSUM_SCHED_TIMEOUT_EN
    chk("err sticky", 64'(err_timeout), 64'(1));
`endif
    tick(1'b1, 1'b0, 4'h0, Z);
    chk("rst err", 64'(err_timeout), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
